demux16_scan: RTL and testbench

DEMUX16_SCAN -- requirements
Module: demux16_scan

---
 rtl/demux16_scan.sv | 86 ++++++++
 tb/tb_demux16_scan.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/demux16_scan.sv
// Sequential scanner for a remote 16:1 mux: steps sel_out through 0..15, waits
// SETTLE cycles after each select change, samples din and emits the assembled word.
module demux16_scan #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        din,
    output logic [3:0]  sel_out,
    output logic [15:0] out,
    output logic        valid,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [3:0]  sel_n;
    logic [15:0] shadow, shadow_n;
    logic [15:0] out_n;
    logic        valid_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            sel_out <= '0;
            shadow  <= '0;
            out     <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            sel_out <= sel_n;
            shadow  <= shadow_n;
            out     <= out_n;
            valid   <= valid_n;
            // busy is registered from the next state so it tracks state!=IDLE exactly
            busy    <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        sel_n    = sel_out;
        shadow_n = shadow;
        out_n    = out;
        valid_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    sel_n   = 4'd0;
                    cnt_n   = SETTLE_C;
                    state_n = SCAN;
                end
            end
            SCAN: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    shadow_n[sel_out] = din;
                    if (sel_out != 4'd15) begin
                        sel_n = sel_out + 4'd1;
                        cnt_n = SETTLE_C;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                out_n   = shadow;
                valid_n = 1'b1;
                sel_n   = 4'd0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_demux16_scan.sv
// Directed bench for demux16_scan: one instance with SETTLE=1, one with SETTLE=0,
// each fed by a remote-mux model din = pattern[sel_out].
module tb_demux16_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1, start0, start1;
    logic [15:0] pat0, pat1;
    logic        din0, din1;
    logic [3:0]  sel0, sel1;
    logic [15:0] out0, out1;
    logic        valid0, valid1, busy0, busy1;

    assign din0 = pat0[sel0];
    assign din1 = pat1[sel1];

    demux16_scan #(.SETTLE(0)) dut0 (
        .clk(clk), .rst(rst0), .start(start0), .din(din0),
        .sel_out(sel0), .out(out0), .valid(valid0), .busy(busy0)
    );

    demux16_scan #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .din(din1),
        .sel_out(sel1), .out(out1), .valid(valid1), .busy(busy1)
    );

    int tests = 0;
    int fails = 0;
    logic [15:0] prior0, prior1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic g_valid(input int s); return s ? valid1 : valid0; endfunction
    function automatic logic g_busy(input int s);  return s ? busy1  : busy0;  endfunction
    function automatic logic [3:0]  g_sel(input int s); return s ? sel1 : sel0; endfunction
    function automatic logic [15:0] g_out(input int s); return s ? out1 : out0; endfunction

    task automatic set_start(input int s, input logic b);
        if (s != 0) start1 = b; else start0 = b;
    endtask

    task automatic set_rst(input int s, input logic b);
        if (s != 0) rst1 = b; else rst0 = b;
    endtask

    // Pulse start, then watch a window beyond the scan. settle must match the instance.
    task automatic run_scan(input int s, input int settle, input logic [15:0] pat,
                            input logic [15:0] exp, input logic [15:0] prior,
                            input bit mid_start, input string tag);
        int len, valid_at, vcnt, sel_bad, busy_bad, out_bad;
        logic [3:0] esel;
        len = 16 * (settle + 1);
        if (s != 0) pat1 = pat; else pat0 = pat;
        @(negedge clk); set_start(s, 1'b1);
        @(negedge clk); set_start(s, 1'b0);
        check({tag, " busy_after_start"}, 32'(g_busy(s)), 32'd1);
        check({tag, " sel_after_start"}, 32'(g_sel(s)), 32'd0);
        valid_at = -1; vcnt = 0; sel_bad = 0; busy_bad = 0; out_bad = 0;
        for (int n = 1; n <= len + 6; n++) begin
            @(negedge clk);
            if (mid_start && n == 10) set_start(s, 1'b1);
            if (mid_start && n == 11) set_start(s, 1'b0);
            esel = (n <= len) ? ((n / (settle + 1)) > 15 ? 4'd15 : 4'(n / (settle + 1))) : 4'd0;
            if (g_sel(s) !== esel) sel_bad++;
            if (g_busy(s) !== (n <= len)) busy_bad++;
            if (g_out(s) !== ((n <= len) ? prior : exp)) out_bad++;
            if (g_valid(s) === 1'b1) begin
                vcnt++;
                if (valid_at < 0) valid_at = n;
            end
        end
        check({tag, " valid_edge"}, 32'(valid_at), 32'(len + 1));
        check({tag, " valid_count"}, 32'(vcnt), 32'd1);
        check({tag, " sel_sequence_errs"}, 32'(sel_bad), 32'd0);
        check({tag, " busy_window_errs"}, 32'(busy_bad), 32'd0);
        check({tag, " out_hold_errs"}, 32'(out_bad), 32'd0);
        check({tag, " out"}, 32'(g_out(s)), 32'(exp));
    endtask

    typedef struct {
        int          s;
        int          settle;
        logic [15:0] pat;
        logic [15:0] exp;
        bit          mid_start;
        string       tag;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int n, v1, v2, vc;

        vecs[0] = '{1, 1, 16'h3F0A, 16'h3F0A, 1'b0, "basic_s1"};
        vecs[1] = '{0, 0, 16'hA5C3, 16'hA5C3, 1'b0, "zero_settle"};
        vecs[2] = '{1, 1, 16'h0000, 16'h0000, 1'b0, "hold_then_zero"};
        vecs[3] = '{1, 1, 16'h8001, 16'h8001, 1'b1, "ignored_start"};
        vecs[4] = '{0, 0, 16'h0001, 16'h0001, 1'b1, "s0_ignored_start"};
        vecs[5] = '{0, 0, 16'hFFFF, 16'hFFFF, 1'b0, "s0_all_ones"};

        rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b1; start1 = 1'b1;
        pat0 = 16'h0; pat1 = 16'h0;

        // reset held two cycles with start asserted: reset wins
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst_out1", 32'(out1), 32'h0);
            check("rst_valid1", 32'(valid1), 32'h0);
            check("rst_busy1", 32'(busy1), 32'h0);
            check("rst_sel1", 32'(sel1), 32'h0);
            check("rst_busy0", 32'(busy0), 32'h0);
            check("rst_out0", 32'(out0), 32'h0);
        end
        start0 = 1'b0; start1 = 1'b0;
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        check("idle_busy1", 32'(busy1), 32'h0);
        prior0 = 16'h0; prior1 = 16'h0;

        for (int i = 0; i < 6; i++) begin
            run_scan(vecs[i].s, vecs[i].settle, vecs[i].pat, vecs[i].exp,
                     (vecs[i].s != 0) ? prior1 : prior0, vecs[i].mid_start, vecs[i].tag);
            if (vecs[i].s != 0) prior1 = vecs[i].exp; else prior0 = vecs[i].exp;
        end

        // held start: back-to-back scans, valid 34 cycles apart
        pat1 = 16'h5A5A;
        @(negedge clk); start1 = 1'b1;
        v1 = -1; v2 = -1;
        for (n = 0; n < 80; n++) begin
            @(negedge clk);
            if (valid1 === 1'b1) begin
                if (v1 < 0) v1 = n; else if (v2 < 0) v2 = n;
            end
        end
        start1 = 1'b0;
        check("held_first_valid", 32'(v1), 32'd33);
        check("held_gap", 32'(v2 - v1), 32'd34);
        check("held_out", 32'(out1), 32'h5A5A);
        repeat (40) @(negedge clk);
        check("held_idle_after", 32'(busy1), 32'd0);

        // abort: reset mid-scan when sel_out reaches 8
        pat1 = 16'hFFFF;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        n = 0;
        while (sel1 !== 4'd8 && n < 40) begin
            @(negedge clk); n++;
        end
        check("abort_reached_sel8", 32'(sel1), 32'd8);
        rst1 = 1'b1;
        @(negedge clk); rst1 = 1'b0;
        check("abort_out", 32'(out1), 32'h0);
        check("abort_busy", 32'(busy1), 32'h0);
        check("abort_sel", 32'(sel1), 32'h0);
        vc = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (valid1 === 1'b1) vc++;
        end
        check("abort_no_valid", 32'(vc), 32'd0);
        check("abort_out_stays", 32'(out1), 32'h0);
        run_scan(1, 1, 16'h0001, 16'h0001, 16'h0000, 1'b0, "after_abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
